// File: rtl/addr_decoder_cfg_loader_if.sv
// addr_decoder_cfg_loader_if: descriptor handshake and config byte-write bus of the window-table loader
interface addr_decoder_cfg_loader_if #(
    parameter int ADDR_W = 32,
    parameter int WIN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_clear;
    logic [WIN_W-1:0]  req_win;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W-1:0] req_mask;
    logic [2:0]        req_slot;
    logic [7:0]        req_op;
    logic              busy;
    logic              done;
    logic              err;
    logic              cfg_we;
    logic [7:0]        cfg_addr;
    logic [7:0]        cfg_wdata;
    modport master (
        output req_valid, req_clear, req_win, req_base, req_mask, req_slot, req_op,
        input  req_ready, busy, done, err, cfg_we, cfg_addr, cfg_wdata
    );
    modport slave (
        input  req_valid, req_clear, req_win, req_base, req_mask, req_slot, req_op,
        output req_ready, busy, done, err, cfg_we, cfg_addr, cfg_wdata
    );
endinterface

// File: rtl/addr_decoder_cfg_loader.sv
// addr_decoder_cfg_loader: serialises window descriptors (or clear-all) into byte-wide decoder cfg writes
module addr_decoder_cfg_loader #(
    parameter int ADDR_W  = 32,
    parameter int NUM_WIN = 16,
    parameter int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input logic                      cfg_clk,
    input logic                      cfg_rst,
    addr_decoder_cfg_loader_if.slave bus
);
    localparam int CFG_BYTES = (ADDR_W + 7) / 8;
    localparam int FW        = CFG_BYTES * 8;
    localparam int MASK_OFF  = NUM_WIN * CFG_BYTES;
    localparam int SLOT_OFF  = MASK_OFF + NUM_WIN * CFG_BYTES;
    localparam int OP_OFF    = SLOT_OFF + NUM_WIN;

    typedef enum logic [2:0] {IDLE, BASE, MASK, SLOT, OP, ERR} state_t;

    state_t           state_q, state_d;
    logic             clear_q, clear_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [FW-1:0]    base_q, base_d, mask_q, mask_d;
    logic [2:0]       slot_q, slot_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       byte_q, byte_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
    logic [7:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic             accept, last_byte, last_win;

    assign accept    = bus.req_valid && ready_q;
    assign last_byte = byte_q == 8'(CFG_BYTES - 1);
    assign last_win  = !clear_q || int'(win_q) == NUM_WIN - 1;

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cfg_we    = we_q;
    assign bus.cfg_addr  = addr_q;
    assign bus.cfg_wdata = wdata_q;

    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            clear_q <= clear_d;
            win_q   <= win_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            slot_q  <= slot_d;
            op_q    <= op_d;
            byte_q  <= byte_d;
        end
    end

    // A clear loads the default descriptor once and then walks win_q across every window.
    always_comb begin
        state_d = state_q;
        clear_d = clear_q;
        win_d   = win_q;
        base_d  = base_q;
        mask_d  = mask_q;
        slot_d  = slot_q;
        op_d    = op_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: if (accept) begin
                clear_d = bus.req_clear;
                win_d   = bus.req_clear ? '0 : bus.req_win;
                base_d  = bus.req_clear ? '0 : FW'(bus.req_base);
                mask_d  = bus.req_clear ? '0 : FW'(bus.req_mask);
                slot_d  = bus.req_clear ? 3'd0 : bus.req_slot;
                op_d    = bus.req_clear ? 8'hFF : bus.req_op;
                byte_d  = '0;
                state_d = (!bus.req_clear && int'(bus.req_win) >= NUM_WIN) ? ERR : BASE;
            end
            BASE: begin
                byte_d  = last_byte ? '0 : byte_q + 8'd1;
                state_d = last_byte ? MASK : BASE;
            end
            MASK: begin
                byte_d  = last_byte ? '0 : byte_q + 8'd1;
                state_d = last_byte ? SLOT : MASK;
            end
            SLOT: state_d = OP;
            OP: begin
                win_d   = win_q + 1'b1;
                state_d = last_win ? IDLE : BASE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered write lands on the cycle after each step.
    always_comb begin
        we_d    = state_d inside {BASE, MASK, SLOT, OP};
        busy_d  = we_d;
        ready_d = state_d == IDLE;
        err_d   = state_d == ERR;
        done_d  = state_d == OP && (!clear_d || int'(win_d) == NUM_WIN - 1);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_d)
            BASE: begin
                addr_d  = 8'(int'(win_d) * CFG_BYTES + int'(byte_d));
                wdata_d = 8'(base_d >> {byte_d, 3'b000});
            end
            MASK: begin
                addr_d  = 8'(MASK_OFF + int'(win_d) * CFG_BYTES + int'(byte_d));
                wdata_d = 8'(mask_d >> {byte_d, 3'b000});
            end
            SLOT: begin
                addr_d  = 8'(SLOT_OFF + int'(win_d));
                wdata_d = {5'b0, slot_d};
            end
            OP: begin
                addr_d  = 8'(OP_OFF + int'(win_d));
                wdata_d = op_d;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_addr_decoder_cfg_loader.sv
// tb_addr_decoder_cfg_loader: vector table, corner sequences and random descriptors against a write-list model
module tb_addr_decoder_cfg_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel, v, clr;
    logic [3:0]  w;
    logic [31:0] base, mask;
    logic [2:0]  slot;
    logic [7:0]  op;

    addr_decoder_cfg_loader_if #(.ADDR_W(32), .WIN_W(4)) i16 ();
    addr_decoder_cfg_loader_if #(.ADDR_W(32), .WIN_W(4)) i12 ();

    assign i16.req_valid = v & ~sel;
    assign i16.req_clear = clr;
    assign i16.req_win   = w;
    assign i16.req_base  = base;
    assign i16.req_mask  = mask;
    assign i16.req_slot  = slot;
    assign i16.req_op    = op;
    assign i12.req_valid = v & sel;
    assign i12.req_clear = clr;
    assign i12.req_win   = w;
    assign i12.req_base  = base;
    assign i12.req_mask  = mask;
    assign i12.req_slot  = slot;
    assign i12.req_op    = op;

    addr_decoder_cfg_loader #(.ADDR_W(32), .NUM_WIN(16), .WIN_W(4)) u16 (.cfg_clk(clk), .cfg_rst(rst), .bus(i16));
    addr_decoder_cfg_loader #(.ADDR_W(32), .NUM_WIN(12), .WIN_W(4)) u12 (.cfg_clk(clk), .cfg_rst(rst), .bus(i12));

    logic       s_we, s_done, s_err, s_busy, s_rdy;
    logic [7:0] s_addr, s_data;
    assign s_we   = sel ? i12.cfg_we    : i16.cfg_we;
    assign s_done = sel ? i12.done      : i16.done;
    assign s_err  = sel ? i12.err       : i16.err;
    assign s_busy = sel ? i12.busy      : i16.busy;
    assign s_rdy  = sel ? i12.req_ready : i16.req_ready;
    assign s_addr = sel ? i12.cfg_addr  : i16.cfg_addr;
    assign s_data = sel ? i12.cfg_wdata : i16.cfg_wdata;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] t1 [10] = '{16'h0878, 16'h0956, 16'h0A34, 16'h0B12, 16'h4800,
                             16'h4900, 16'h4AFF, 16'h4BFF, 16'h8205, 16'h923C};

    typedef struct {
        bit          s;
        bit          c;
        logic [3:0]  w;
        logic [31:0] b;
        logic [31:0] m;
        logic [2:0]  sl;
        logic [7:0]  o;
        int          n;
        logic [15:0] last;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expected write list straight from the layout rules: every window, every field, LSB byte first.
    function automatic void model(input bit c, input int wi, input logic [31:0] b, input logic [31:0] m,
                                  input logic [2:0] s, input logic [7:0] o, input int nw);
        int lo, hi;
        exp_q.delete();
        if (!c && wi >= nw) return;
        lo = c ? 0 : wi;
        hi = c ? nw - 1 : wi;
        for (int x = lo; x <= hi; x++) begin
            logic [31:0] vb, vm;
            logic [7:0]  vs, vo;
            vb = c ? 32'd0 : b;
            vm = c ? 32'd0 : m;
            vs = c ? 8'd0 : {5'd0, s};
            vo = c ? 8'hFF : o;
            for (int k = 0; k < 4; k++) exp_q.push_back({8'(x * 4 + k), 8'(vb >> (8 * k))});
            for (int k = 0; k < 4; k++) exp_q.push_back({8'(nw * 4 + x * 4 + k), 8'(vm >> (8 * k))});
            exp_q.push_back({8'(nw * 8 + x), vs});
            exp_q.push_back({8'(nw * 9 + x), vo});
        end
    endfunction

    task automatic run(input bit s, input bit c, input logic [3:0] wi, input logic [31:0] b, input logic [31:0] m,
                       input logic [2:0] sl, input logic [7:0] o, input bit scr, input bit hold);
        int t, gaps, bad, mis;
        sel = s; clr = c; w = wi; base = b; mask = m; slot = sl; op = o; v = 1'b1;
        model(c, int'(wi), b, m, sl, o, s ? 12 : 16);
        got_q.delete();
        t = 0;
        while (!s_rdy && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", t < 300, 1);
        @(negedge clk);
        if (!hold) v = 1'b0;
        if (exp_q.size() == 0) begin
            chk("err_pulse", s_err, 1);
            chk("err_no_we", s_we, 0);
            chk("err_rdy_lo", s_rdy, 0);
            @(negedge clk);
            chk("err_gone", s_err, 0);
            chk("err_rdy_hi", s_rdy, 1);
            chk("err_no_done", s_done | s_we, 0);
            return;
        end
        t = 0; gaps = 0; bad = 0;
        forever begin
            if (s_we) got_q.push_back({s_addr, s_data}); else gaps++;
            if (s_busy !== 1'b1 || s_rdy !== 1'b0 || s_err !== 1'b0) bad++;
            if (s_done || t >= 400) break;
            if (scr) begin
                v = 1'($urandom); clr = 1'($urandom); w = 4'($urandom); base = $urandom;
                mask = $urandom; slot = 3'($urandom); op = 8'($urandom);
            end
            @(negedge clk);
            t++;
        end
        chk("done_seen", s_done, 1);
        chk("write_gaps", gaps, 0);
        chk("busy_ready_during_seq", bad, 0);
        chk("write_count", got_q.size(), exp_q.size());
        mis = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                if (mis == 0) $display("  first diff at write %0d: got %h, expected %h", i, got_q[i], exp_q[i]);
                mis++;
            end
        chk("write_stream", mis, 0);
        @(negedge clk);
        v = hold;
        chk("dead_no_we", s_we, 0);
        chk("dead_ready", s_rdy, 1);
        chk("dead_no_done", s_done | s_busy, 0);
    endtask

    task automatic cmp_t1(input string nm);
        int mis = 0;
        for (int i = 0; i < 10; i++) if (i >= got_q.size() || got_q[i] !== t1[i]) mis++;
        chk(nm, mis, 0);
        chk({nm, "_len"}, got_q.size(), 10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; v = 0; clr = 0; w = 0; base = 0; mask = 0; slot = 0; op = 0;
        tbl[0] = '{0, 0, 4'd2,  32'h12345678, 32'hFFFF0000, 3'd5, 8'h3C, 10,  16'h923C};
        tbl[1] = '{0, 0, 4'd0,  32'h00000000, 32'hFFFFFFFF, 3'd7, 8'h00, 10,  16'h9000};
        tbl[2] = '{0, 0, 4'd15, 32'hDEADBEEF, 32'hF0F0F0F0, 3'd3, 8'hA5, 10,  16'h9FA5};
        tbl[3] = '{0, 1, 4'd7,  32'h11111111, 32'h22222222, 3'd1, 8'h01, 160, 16'h9FFF};
        tbl[4] = '{1, 0, 4'd11, 32'hCAFEF00D, 32'h0000FFFF, 3'd6, 8'h11, 10,  16'h7711};
        tbl[5] = '{1, 0, 4'd13, 32'h01234567, 32'h89ABCDEF, 3'd2, 8'h22, 0,   16'h0000};
        tbl[6] = '{1, 1, 4'd3,  32'h55555555, 32'hAAAAAAAA, 3'd4, 8'h44, 120, 16'h77FF};
        tbl[7] = '{1, 0, 4'd0,  32'h00000001, 32'h00000002, 3'd1, 8'h80, 10,  16'h6C80};

        repeat (3) @(negedge clk);
        chk("rst_we16", i16.cfg_we, 0);
        chk("rst_ready16", i16.req_ready, 0);
        chk("rst_flags16", {i16.busy, i16.done, i16.err}, 0);
        chk("rst_bus16", {i16.cfg_addr, i16.cfg_wdata}, 0);
        chk("rst_ready12", i12.req_ready, 0);
        rst = 0;
        @(negedge clk);
        chk("rel_ready16", i16.req_ready, 1);
        chk("rel_ready12", i12.req_ready, 1);

        run(0, 0, 4'd2, 32'h12345678, 32'hFFFF0000, 3'd5, 8'h3C, 0, 0);
        cmp_t1("basic_win2");

        run(0, 1, 4'd0, 32'h0, 32'h0, 3'd0, 8'h0, 0, 0);
        chk("clear_first", got_q.size() > 0 ? got_q[0] : 16'hFFFF, 16'h0000);
        chk("clear_w0_slot", got_q.size() > 8 ? got_q[8] : 16'hFFFF, 16'h8000);
        chk("clear_last", got_q.size() > 159 ? got_q[159] : 16'h0000, 16'h9FFF);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].s, tbl[i].c, tbl[i].w, tbl[i].b, tbl[i].m, tbl[i].sl, tbl[i].o, 0, 0);
            chk($sformatf("tbl%0d_n", i), got_q.size(), tbl[i].n);
            if (tbl[i].n > 0 && got_q.size() > 0) chk($sformatf("tbl%0d_last", i), got_q[got_q.size() - 1], tbl[i].last);
        end

        // valid held across two descriptors: second one must start right after the dead cycle
        run(0, 0, 4'd4, 32'hA1B2C3D4, 32'h0F0F0F0F, 3'd2, 8'h5A, 0, 1);
        run(0, 0, 4'd5, 32'h0BADF00D, 32'hFFFFFFFF, 3'd6, 8'h77, 0, 0);

        // reset after the third write abandons the sequence
        sel = 0; clr = 0; w = 4'd2; base = 32'h12345678; mask = 32'hFFFF0000; slot = 3'd5; op = 8'h3C; v = 1;
        @(negedge clk);
        v = 0;
        chk("rst_seq_w1", {s_we, s_addr}, {1'b1, 8'h08});
        repeat (2) @(negedge clk);
        chk("rst_seq_w3", {s_we, s_addr, s_data}, {1'b1, 8'h0A, 8'h34});
        rst = 1;
        @(negedge clk);
        chk("rst_mid_we", s_we, 0);
        chk("rst_mid_ready", s_rdy, 0);
        chk("rst_mid_done", s_done | s_busy, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_rel_ready", s_rdy, 1);
        begin
            int stray = 0;
            repeat (12) begin
                if (s_we || s_done) stray++;
                @(negedge clk);
            end
            chk("rst_no_stray", stray, 0);
        end

        run(0, 0, 4'd2, 32'h12345678, 32'hFFFF0000, 3'd5, 8'h3C, 1, 0);
        cmp_t1("scrambled_inputs");

        for (int i = 0; i < 30; i++)
            run(1'($urandom), ($urandom_range(9) == 0), 4'($urandom), $urandom, $urandom,
                3'($urandom), 8'($urandom), 1'($urandom), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
